// File: rtl/input_ctrl.sv
// -----------------------------------------------------------------------------
// input_ctrl -- front-panel input stage for the washer controller.
//
// Samples the raw seat sensor and seven panel buttons, synchronises and
// debounces each one, and turns button presses into the level-type reg_*
// request bits (plus warm_en) consumed by core. Request bits that core acts
// on drop again on core's status / done flags.
//
// Build option:
//   INPUT_CTRL_DEBOUNCE_EN  defined   : per-input DEB_CNT-cycle debounce.
//                           undefined : debounce removed, deb = s2 (fast sim).
//
// Parameters:
//   DEB_CNT  stable cycles needed to accept a level change (2..32767)
//   CW       debounce counter width, 2**CW > DEB_CNT
//
// Ports:
//   clk, reset_n           1 MHz clock, async active-low reset
//   seat_sensor            raw seat sensor (1 = seated)
//   btn_*                  raw active-high panel buttons
//   stt_using, stt_ready   core state flags (request qualifiers)
//   count_spray_done,
//   count_dis_done         core one-cycle done pulses (request clears)
//   reg_*, warm_en         registered control bits to core
// -----------------------------------------------------------------------------

// One raw input: 2-FF synchroniser followed by the (optional) debouncer.
module input_ctrl_lane #(
    parameter int DEB_CNT = 20000,
    parameter int CW      = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic deb
);
    logic s1, s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef INPUT_CTRL_DEBOUNCE_EN
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

    logic [CW-1:0] cnt;

    // Counter only runs while s2 disagrees with deb; any agreement clears it,
    // so a glitch shorter than DEB_CNT cycles never reaches deb. The counter
    // is capped at CNT_MAX and cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (s2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            deb <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign deb = s2;
`endif

endmodule

module input_ctrl #(
    parameter int DEB_CNT = 20000,
    parameter int CW      = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic seat_sensor,
    input  logic btn_wash,
    input  logic btn_spray,
    input  logic btn_mode,
    input  logic btn_auto,
    input  logic btn_auto_dis,
    input  logic btn_de_ur,
    input  logic btn_warm,
    input  logic stt_using,
    input  logic stt_ready,
    input  logic count_spray_done,
    input  logic count_dis_done,
    output logic reg_user_en,
    output logic reg_wash_using,
    output logic reg_spray_en,
    output logic reg_spray_mode,
    output logic reg_sp_dr_auto_en,
    output logic reg_auto_dis_en,
    output logic reg_de_ur,
    output logic warm_en
);
    localparam int NUM_IN = 8;

    // Lane index map.
    localparam int I_SEAT  = 0;
    localparam int I_WASH  = 1;
    localparam int I_SPRAY = 2;
    localparam int I_MODE  = 3;
    localparam int I_AUTO  = 4;
    localparam int I_ADIS  = 5;
    localparam int I_DEUR  = 6;
    localparam int I_WARM  = 7;

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] deb;
    // The seat sensor is level-type, so edge detection only covers buttons.
    logic [NUM_IN-1:1] deb_d;
    logic [NUM_IN-1:1] press;

    assign raw = {btn_warm, btn_de_ur, btn_auto_dis, btn_auto,
                  btn_mode, btn_spray, btn_wash, seat_sensor};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        input_ctrl_lane #(
            .DEB_CNT (DEB_CNT),
            .CW      (CW)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (raw[i]),
            .deb     (deb[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) deb_d <= '0;
        else          deb_d <= deb[NUM_IN-1:1];
    end

    // Single-cycle pulse on the debounced rising edge; hold and release give
    // nothing further.
    assign press = deb[NUM_IN-1:1] & ~deb_d;

    // Each request bit is evaluated independently, so simultaneous presses on
    // different buttons are all honoured. Where a set and a clear coincide the
    // clear is tested first and wins. Unqualified presses are simply dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_user_en       <= 1'b0;
            reg_wash_using    <= 1'b0;
            reg_spray_en      <= 1'b0;
            reg_spray_mode    <= 1'b0;
            reg_sp_dr_auto_en <= 1'b0;
            reg_auto_dis_en   <= 1'b1;
            reg_de_ur         <= 1'b0;
            warm_en           <= 1'b0;
        end else begin
            reg_user_en <= deb[I_SEAT];

            // Clear on the next value of reg_user_en so wash drops on the
            // same edge as the user-present bit and is never 1 without it.
            if (!deb[I_SEAT])
                reg_wash_using <= 1'b0;
            else if (press[I_WASH] && reg_user_en)
                reg_wash_using <= 1'b1;

            if (count_spray_done)
                reg_spray_en <= 1'b0;
            else if (press[I_SPRAY] && stt_using)
                reg_spray_en <= 1'b1;

            if (count_dis_done)
                reg_de_ur <= 1'b0;
            else if (press[I_DEUR] && stt_ready)
                reg_de_ur <= 1'b1;

            if (press[I_MODE]) reg_spray_mode    <= ~reg_spray_mode;
            if (press[I_AUTO]) reg_sp_dr_auto_en <= ~reg_sp_dr_auto_en;
            if (press[I_ADIS]) reg_auto_dis_en   <= ~reg_auto_dis_en;
            if (press[I_WARM]) warm_en           <= ~warm_en;
        end
    end

endmodule

// File: tb/tb_input_ctrl.sv
// Bench for input_ctrl with DEB_CNT=4. Expected output vectors are queued
// with the clock edge they must appear at; a negedge monitor pops and checks.
// Output vector bit order:
//   7 user_en, 6 wash_using, 5 spray_en, 4 spray_mode,
//   3 sp_dr_auto_en, 2 auto_dis_en, 1 de_ur, 0 warm_en
module tb_input_ctrl;
    localparam int DEB_CNT = 4;
`ifdef INPUT_CTRL_DEBOUNCE_EN
    localparam int LAT = 3 + DEB_CNT;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic seat_sensor = 1'b0, btn_wash = 1'b0, btn_spray = 1'b0, btn_mode = 1'b0;
    logic btn_auto = 1'b0, btn_auto_dis = 1'b0, btn_de_ur = 1'b0, btn_warm = 1'b0;
    logic stt_using = 1'b0, stt_ready = 1'b0;
    logic count_spray_done = 1'b0, count_dis_done = 1'b0;
    logic reg_user_en, reg_wash_using, reg_spray_en, reg_spray_mode;
    logic reg_sp_dr_auto_en, reg_auto_dis_en, reg_de_ur, warm_en;

    input_ctrl #(.DEB_CNT(DEB_CNT), .CW(15)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .seat_sensor       (seat_sensor),
        .btn_wash          (btn_wash),
        .btn_spray         (btn_spray),
        .btn_mode          (btn_mode),
        .btn_auto          (btn_auto),
        .btn_auto_dis      (btn_auto_dis),
        .btn_de_ur         (btn_de_ur),
        .btn_warm          (btn_warm),
        .stt_using         (stt_using),
        .stt_ready         (stt_ready),
        .count_spray_done  (count_spray_done),
        .count_dis_done    (count_dis_done),
        .reg_user_en       (reg_user_en),
        .reg_wash_using    (reg_wash_using),
        .reg_spray_en      (reg_spray_en),
        .reg_spray_mode    (reg_spray_mode),
        .reg_sp_dr_auto_en (reg_sp_dr_auto_en),
        .reg_auto_dis_en   (reg_auto_dis_en),
        .reg_de_ur         (reg_de_ur),
        .warm_en           (warm_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] model;
    logic [7:0] obs;

    assign obs = {reg_user_en, reg_wash_using, reg_spray_en, reg_spray_mode,
                  reg_sp_dr_auto_en, reg_auto_dis_en, reg_de_ur, warm_en};

    always @(posedge clk) cyc <= cyc + 1;

    // Check every queued expectation that is due; an entry whose edge has
    // already passed unchecked also counts as a failure.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].edge_n <= cyc) begin
                checks++;
                assert (sb[i].edge_n == cyc && obs === sb[i].val)
                else begin
                    failures++;
                    $error("FAIL %s: observed=%b expected=%b (edge %0d, now %0d)",
                           sb[i].tag, obs, sb[i].val, sb[i].edge_n, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int e, input logic [7:0] v, input string t);
        exp_t x;
        x.edge_n = e;
        x.val    = v;
        x.tag    = t;
        sb.push_back(x);
    endtask

    // Expect the outputs to change to v exactly at edge e (old value at e-1).
    task automatic expect_at(input int e, input logic [7:0] v, input string t);
        push(e - 1, model, {t, "_pre"});
        push(e, v, t);
        model = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        // Reset with every raw input high.
        {seat_sensor, btn_wash, btn_spray, btn_mode, btn_auto,
         btn_auto_dis, btn_de_ur, btn_warm} = 8'hFF;
        model = 8'b0000_0100;
        tick(3);
        push(cyc, model, "reset_hold");
        tick(1);
        e = cyc;
        reset_n = 1'b1;
        // Inputs pass full latency after reset; wash press lands before user_en.
        expect_at(e + LAT, 8'b1001_1001, "reset_release");
        push(e + LAT + 3, 8'b1001_1001, "reset_settled");
        tick(LAT + 4);

        // Release all buttons: release yields no press.
        {btn_wash, btn_spray, btn_mode, btn_auto, btn_auto_dis, btn_de_ur, btn_warm} = '0;
        push(cyc + LAT + 2, model, "release_no_press");
        tick(LAT + 4);

        // Short btn_mode pulse: rejected with debounce, toggles without it.
        e = cyc;
        btn_mode = 1'b1;
`ifdef INPUT_CTRL_DEBOUNCE_EN
        push(e + LAT, model, "glitch_rejected");
        push(e + LAT + 2, model, "glitch_rejected_late");
`else
        expect_at(e + 3, model ^ 8'b0001_0000, "glitch_passes");
`endif
        tick(3);
        btn_mode = 1'b0;
        tick(LAT + 4);

        // Held btn_mode: a single toggle.
        e = cyc;
        btn_mode = 1'b1;
        expect_at(e + LAT, model ^ 8'b0001_0000, "mode_hold");
        push(e + LAT + 3, model, "mode_single_toggle");
        tick(10);
        btn_mode = 1'b0;
        push(cyc + LAT + 2, model, "mode_release");
        tick(LAT + 4);

        // Wash qualification on the seat.
        e = cyc;
        seat_sensor = 1'b0;
        expect_at(e + LAT, model & 8'b0111_1111, "seat_off");
        tick(LAT + 2);
        e = cyc;
        btn_wash = 1'b1;
        push(e + LAT, model, "wash_no_seat");
        push(e + LAT + 2, model, "wash_no_seat_late");
        tick(LAT + 4);
        btn_wash = 1'b0;
        tick(LAT + 3);
        e = cyc;
        seat_sensor = 1'b1;
        expect_at(e + LAT, model | 8'b1000_0000, "seat_on");
        tick(LAT + 2);
        e = cyc;
        btn_wash = 1'b1;
        expect_at(e + LAT, model | 8'b0100_0000, "wash_set");
        tick(LAT + 2);
        btn_wash = 1'b0;
        tick(LAT + 3);
        e = cyc;
        seat_sensor = 1'b0;
        expect_at(e + LAT, model & 8'b0011_1111, "seat_drop_clears_wash");
        tick(LAT + 2);

        // Spray: set, then clear colliding with a second accepted press.
        stt_using = 1'b1;
        e = cyc;
        btn_spray = 1'b1;
        expect_at(e + LAT, model | 8'b0010_0000, "spray_set");
        tick(LAT + 2);
        btn_spray = 1'b0;
        tick(LAT + 3);
        e = cyc;
        btn_spray = 1'b1;
        expect_at(e + LAT, model & 8'b1101_1111, "spray_clear_wins");
        tick(LAT - 1);
        count_spray_done = 1'b1;
        tick(1);
        count_spray_done = 1'b0;
        tick(3);
        btn_spray = 1'b0;
        push(cyc + LAT + 1, model, "spray_after_collision");
        tick(LAT + 3);

        // Discharge request: set, clear on done pulse, ignored when not ready.
        stt_ready = 1'b1;
        e = cyc;
        btn_de_ur = 1'b1;
        expect_at(e + LAT, model | 8'b0000_0010, "deur_set");
        tick(LAT + 2);
        btn_de_ur = 1'b0;
        tick(2);
        count_dis_done = 1'b1;
        expect_at(cyc + 1, model & 8'b1111_1101, "deur_done_clear");
        tick(1);
        count_dis_done = 1'b0;
        tick(LAT + 2);
        stt_ready = 1'b0;
        e = cyc;
        btn_de_ur = 1'b1;
        push(e + LAT, model, "deur_not_ready");
        push(e + LAT + 2, model, "deur_not_ready_late");
        tick(LAT + 4);
        btn_de_ur = 1'b0;
        tick(LAT + 3);

        // Simultaneous presses toggle independently in the same cycle.
        e = cyc;
        {btn_auto, btn_auto_dis, btn_warm} = 3'b111;
        expect_at(e + LAT, model ^ 8'b0000_1101, "multi_press");
        tick(LAT + 2);
        {btn_auto, btn_auto_dis, btn_warm} = 3'b000;
        tick(LAT + 3);

        // Reset mid-debounce with btn_warm held: full latency again, one press.
        btn_warm = 1'b1;
        tick(2);
        reset_n = 1'b0;
        model = 8'b0000_0100;
        push(cyc, model, "mid_reset");
        tick(2);
        reset_n = 1'b1;
        expect_at(cyc + LAT, 8'b0000_0101, "reset_redebounce");
        tick(LAT + 3);
        btn_warm = 1'b0;
        tick(LAT + 3);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        checks++;
        assert (sb.size() == 0)
        else begin
            failures++;
            $error("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
